// File: rtl/up_counter.sv
// Enable-gated modulo-MODULO binary up-counter with a combinational terminal-count
// flag and a registered one-cycle wrap pulse.
module up_counter #(
    parameter int unsigned      WIDTH  = 4,
    parameter longint unsigned  MODULO = 64'd1 << WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Terminal value; computed in 64 bits so WIDTH=32 with the full modulus is exact.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 64'd1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULO < 64'd2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_params
            $error("up_counter: illegal WIDTH/MODULO combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + WIDTH'(1);
            r_wrap  <= w_at_last;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = w_at_last;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: a full-modulus (16) and a short-modulus (10)
// instance run side by side against an arithmetic reference model.
module tb_up_counter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] count16, count10;
    logic       tc16, tc10, wrap16, wrap10;

    int checks   = 0;
    int failures = 0;

    // Reference model: count as plain integer modulo arithmetic per instance.
    int   mod_of [2] = '{16, 10};
    int   m_cnt  [2];
    logic m_wrap [2];

    up_counter #(.WIDTH(4)) dut16 (
        .clock(clock), .reset(reset), .enable(enable),
        .count(count16), .tc(tc16), .wrap(wrap16)
    );

    up_counter #(.WIDTH(4), .MODULO(10)) dut10 (
        .clock(clock), .reset(reset), .enable(enable),
        .count(count10), .tc(tc10), .wrap(wrap10)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s m16 count", tag), 32'(count16), 32'(m_cnt[0]));
        check($sformatf("%s m16 tc",    tag), 32'(tc16),    32'(m_cnt[0] == mod_of[0] - 1));
        check($sformatf("%s m16 wrap",  tag), 32'(wrap16),  32'(m_wrap[0]));
        check($sformatf("%s m10 count", tag), 32'(count10), 32'(m_cnt[1]));
        check($sformatf("%s m10 tc",    tag), 32'(tc10),    32'(m_cnt[1] == mod_of[1] - 1));
        check($sformatf("%s m10 wrap",  tag), 32'(wrap10),  32'(m_wrap[1]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic en);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i]  = (m_cnt[i] + int'(en)) % mod_of[i];
                m_wrap[i] = en && (m_cnt[i] == 0);
            end
        end
    endtask

    // Called at a falling edge; leaves the caller at the next falling edge.
    task automatic step(input logic en, input string tag);
        enable = en;
        @(posedge clock);
        model_edge(en);
        #1;
        check_all(tag);
        @(negedge clock);
    endtask

    // Pulls reset low mid-cycle, checks the async clear and the hold across an
    // enabled edge, then releases reset at the following falling edge.
    task automatic mid_cycle_reset(input string tag);
        enable = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all({tag, " async clear"});
        @(posedge clock);
        #1;
        check_all({tag, " held in reset"});
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        model_reset();
        #1;
        check_all("reset t0");
        @(negedge clock);
        reset = 1'b1;

        // Ten enabled edges from zero, then on through the 16-state wrap.
        for (int i = 0; i < 10; i++) step(1'b1, $sformatf("run10 #%0d", i));
        for (int i = 10; i < 20; i++) step(1'b1, $sformatf("run20 #%0d", i));

        // Reach 7, stall five cycles, resume.
        mid_cycle_reset("pre-hold");
        for (int i = 0; i < 7; i++) step(1'b1, "to7");
        check("at7", 32'(count16), 32'd7);
        for (int i = 0; i < 5; i++) step(1'b0, "hold7");
        step(1'b1, "resume8");

        // Reach 9, then reset in the middle of a cycle with enable high.
        for (int i = 0; i < 1; i++) step(1'b1, "to9");
        check("at9", 32'(count16), 32'd9);
        mid_cycle_reset("mid9");
        step(1'b1, "after mid9");

        // tc around 14/15 with enable low and high.
        mid_cycle_reset("pre-tc");
        for (int i = 0; i < 14; i++) step(1'b1, "to14");
        step(1'b0, "idle14");
        step(1'b1, "to15");
        check("tc at 15", 32'(tc16), 32'd1);
        step(1'b0, "idle15 a");
        step(1'b0, "idle15 b");
        step(1'b1, "wrap15");
        check("wrap pulse", 32'(wrap16), 32'd1);
        step(1'b1, "after wrap");
        check("wrap one-shot", 32'(wrap16), 32'd0);

        // Randomized enable with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) mid_cycle_reset($sformatf("rnd rst %0d", i));
            step(($urandom_range(0, 3) != 0), $sformatf("rnd %0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
